// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Shares one externally instantiated, clocked fp_add between two requesters.
//   Round-robin grant (one issue per clock), a tag pipe matched to the adder
//   latency, and a per-requester in-order response FIFO with valid/ready.
//
//   Parameters:
//     ADD_LAT   clocks from add_a/add_b registered to add_out sampled (1..8)
//     RSP_DEPTH response FIFO entries per requester (power of 2, >= 2)
//
//   Ports:
//     clk, rst                  clock (rising edge), async active-high reset
//     rN_valid/rN_ready         request handshake, operands rN_a/rN_b
//     rN_rsp_valid/rN_rsp_ready response handshake, sum on rN_rsp_data
//     add_a, add_b              registered operands to the shared fp_add
//     add_out                   sum returned by the shared fp_add
//
//   Optional (macro FP_ARB_STATS_EN): r0_grants, r1_grants, stall_cycles,
//   16-bit saturating counters.
module fp_add_arbiter #(
  parameter int unsigned ADD_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_data,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out
`ifdef FP_ARB_STATS_EN
  ,
  output logic [15:0] r0_grants,
  output logic [15:0] r1_grants,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(RSP_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_e;

  req_e               last_q;
  logic [1:0]         req_valid, rsp_rdy, elig, grant, push, pop, rsp_v, full;
  logic [CW-1:0]      used   [2];   // buffered entries + in-flight ops
  logic [PW-1:0]      wr_ptr [2];
  logic [PW-1:0]      rd_ptr [2];
  logic [31:0]        mem    [2][RSP_DEPTH];
  logic [ADD_LAT-1:0] tag_v, tag_id;
  logic               done, done_id;

  assign req_valid = {r1_valid, r0_valid};
  assign rsp_rdy   = {r1_rsp_ready, r0_rsp_ready};
  assign done      = tag_v[ADD_LAT-1];
  assign done_id   = tag_id[ADD_LAT-1];
  assign push      = {done & done_id, done & ~done_id};

  // Credits come from registered counts only, so a pop frees a slot for
  // arbitration in the following cycle.
  always_comb begin
    elig  = '0;
    grant = '0;
    rsp_v = '0;
    full  = '0;
    pop   = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      elig[n]  = req_valid[n] && (used[n] < CW'(RSP_DEPTH));
      rsp_v[n] = (wr_ptr[n] != rd_ptr[n]);
      full[n]  = ((wr_ptr[n] - rd_ptr[n]) == PW'(RSP_DEPTH));
      pop[n]   = rsp_v[n] && rsp_rdy[n];
    end
    if (!rst) begin
      if (elig[0] && (!elig[1] || last_q == REQ1)) grant[0] = 1'b1;
      else if (elig[1])                            grant[1] = 1'b1;
    end
  end

  assign r0_ready     = grant[0];
  assign r1_ready     = grant[1];
  assign r0_rsp_valid = rsp_v[0];
  assign r1_rsp_valid = rsp_v[1];
  assign r0_rsp_data  = mem[0][rd_ptr[0][AW-1:0]];
  assign r1_rsp_data  = mem[1][rd_ptr[1][AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ1;
      add_a  <= '0;
      add_b  <= '0;
      tag_v  <= '0;
      tag_id <= '0;
      for (int unsigned n = 0; n < 2; n++) begin
        used[n]   <= '0;
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        for (int unsigned i = 0; i < RSP_DEPTH; i++) mem[n][i] <= '0;
      end
    end else begin
      if (|grant) begin
        last_q <= grant[1] ? REQ1 : REQ0;
        add_a  <= grant[1] ? r1_a : r0_a;
        add_b  <= grant[1] ? r1_b : r0_b;
      end
      for (int unsigned i = ADD_LAT - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= |grant;
      tag_id[0] <= grant[1];
      for (int unsigned n = 0; n < 2; n++) begin
        // A completion moves an op from in-flight to buffered; used is unchanged.
        unique case ({grant[n], pop[n]})
          2'b10:   used[n] <= used[n] + CW'(1);
          2'b01:   used[n] <= used[n] - CW'(1);
          default: ;
        endcase
        if (push[n]) begin
          assert (!full[n]) else $error("response buffer %0d overflow", n);
          mem[n][wr_ptr[n][AW-1:0]] <= add_out;
          wr_ptr[n] <= wr_ptr[n] + PW'(1);
        end
        if (pop[n]) rd_ptr[n] <= rd_ptr[n] + PW'(1);
      end
    end
  end

`ifdef FP_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_grants    <= '0;
      r1_grants    <= '0;
      stall_cycles <= '0;
    end else begin
      if (grant[0] && r0_grants != '1) r0_grants <= r0_grants + 16'd1;
      if (grant[1] && r1_grants != '1) r1_grants <= r1_grants + 16'd1;
      if ((|req_valid) && !(|grant) && stall_cycles != '1)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
